stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_stall_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Pipeline stall controller for a five-stage core.
// Detects register data hazards between the instruction in D and the
// producers in E/M using the tuse/tnew scheme, tracks the multi-cycle
// HI/LO unit, and keeps a saturating count of stall cycles.
module stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic [4:0]  E_waddr,
    input  logic [4:0]  M_waddr,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        D_is_md,
    input  logic [1:0]  E_md_start,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    // Busy counter width; holds the larger of the two latencies (up to 15).
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] START_MUL = 2'b01;
    localparam logic [1:0] START_DIV = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] md_cnt, md_cnt_d;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;
    logic start_any;

    // A source stalls when a producer in E or M targets it and its value
    // will not be forwardable by the time D's instruction consumes it.
    // Register 0 and unused sources (tuse == 3) never stall. E and M are
    // checked independently so a ready M result cannot mask a late E one.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_waddr,
        input logic [1:0] e_tnew,
        input logic [4:0] m_waddr,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (src == e_waddr) && (tuse < e_tnew);
        m_hit = (src == m_waddr) && (tuse < m_tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Encoding 11 is deliberately treated the same as "no start".
    assign start_any = (E_md_start == START_MUL) || (E_md_start == START_DIV);

    // Hazard detection: purely combinational so the stall takes effect in
    // the same cycle the hazard is visible.
    always_comb begin
        stall_rs = src_hazard(D_rs, D_tuse_rs, E_waddr, E_tnew, M_waddr, M_tnew);
        stall_rt = src_hazard(D_rt, D_tuse_rt, E_waddr, E_tnew, M_waddr, M_tnew);
        stall_md = D_is_md && (md_busy || start_any);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Pipeline enables: freeze PC and D, inject a bubble into E on stall.
    always_comb begin
        pc_en = 1'b1;
        d_en  = 1'b1;
        e_clr = 1'b0;
        if (stall) begin
            pc_en = 1'b0;
            d_en  = 1'b0;
            e_clr = 1'b1;
        end
    end

    // HI/LO busy FSM next state: load on a start from IDLE, count down in
    // BUSY, and ignore any start that arrives while already busy.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt;
        case (state_q)
            IDLE: begin
                if (E_md_start == START_MUL) begin
                    md_cnt_d = MULT_LD;
                end else if (E_md_start == START_DIV) begin
                    md_cnt_d = DIV_LD;
                end
                state_d = (md_cnt_d != '0) ? BUSY : IDLE;
            end
            BUSY: begin
                md_cnt_d = md_cnt - 1'b1;
                state_d  = (md_cnt_d == '0) ? IDLE : BUSY;
            end
            default: begin
                md_cnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // HI/LO busy FSM state register; reset aborts any count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            md_cnt  <= '0;
        end else begin
            state_q <= state_d;
            md_cnt  <= md_cnt_d;
        end
    end

    assign md_busy = (state_q == BUSY);

    // Saturating count of every cycle spent stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: a reference model pushes the expected
// outputs for every driven cycle onto a queue; a monitor pops and compares
// them mid-cycle. Directed checks cover the latency windows and boundaries.
module tb_stall_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_waddr, M_waddr;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew, E_md_start;
    logic        D_is_md;
    logic        pc_en, d_en, e_clr, md_busy;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [1:0] trs;
        logic [4:0] rt;
        logic [1:0] trt;
        logic [4:0] ew;
        logic [1:0] et;
        logic [4:0] mw;
        logic [1:0] mt;
        logic       md;
        logic [1:0] st;
    } stim_t;

    typedef struct packed {
        logic        pc_en;
        logic        d_en;
        logic        e_clr;
        logic        busy;
        logic [15:0] scnt;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_scnt = 0;

    stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .E_waddr(E_waddr), .M_waddr(M_waddr),
        .E_tnew(E_tnew), .M_tnew(M_tnew),
        .D_is_md(D_is_md), .E_md_start(E_md_start),
        .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mdl_hz(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] ew, input logic [1:0] et,
                                  input logic [4:0] mw, input logic [1:0] mt);
        if (src == 5'd0)  return 1'b0;
        if (tuse == 2'd3) return 1'b0;
        if (src == ew && int'(tuse) < int'(et)) return 1'b1;
        if (src == mw && int'(tuse) < int'(mt)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.trs = 2'd3;
        s.trt = 2'd3;
        return s;
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, then
    // advance the model across the coming edge.
    task automatic step(input stim_t s);
        exp_t e;
        bit   stl;
        bit   md_start;
        @(posedge clk);
        #1;
        reset      = s.rst;
        D_rs       = s.rs;  D_tuse_rs = s.trs;
        D_rt       = s.rt;  D_tuse_rt = s.trt;
        E_waddr    = s.ew;  E_tnew    = s.et;
        M_waddr    = s.mw;  M_tnew    = s.mt;
        D_is_md    = s.md;  E_md_start = s.st;
        md_start = (s.st == 2'b01) || (s.st == 2'b10);
        stl = mdl_hz(s.rs, s.trs, s.ew, s.et, s.mw, s.mt)
           || mdl_hz(s.rt, s.trt, s.ew, s.et, s.mw, s.mt)
           || (s.md && (m_cnt != 0 || md_start));
        e.pc_en = !stl;
        e.d_en  = !stl;
        e.e_clr = stl;
        e.busy  = (m_cnt != 0);
        e.scnt  = 16'(m_scnt);
        sb.push_back(e);
        if (s.rst) begin
            m_cnt  = 0;
            m_scnt = 0;
        end else begin
            if (m_cnt != 0)          m_cnt = m_cnt - 1;
            else if (s.st == 2'b01)  m_cnt = MULT_CYC;
            else if (s.st == 2'b10)  m_cnt = DIV_CYC;
            if (stl && m_scnt < 65535) m_scnt = m_scnt + 1;
        end
    endtask

    // Scoreboard monitor: compare mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_pc_en",     32'(pc_en),     32'(e.pc_en));
            check("sb_d_en",      32'(d_en),      32'(e.d_en));
            check("sb_e_clr",     32'(e_clr),     32'(e.e_clr));
            check("sb_md_busy",   32'(md_busy),   32'(e.busy));
            check("sb_stall_cnt", 32'(stall_cnt), 32'(e.scnt));
        end
    end

    initial begin
        stim_t s;
        int    nb;
        logic [15:0] c0;

        reset = 1'b1;
        D_rs = '0; D_rt = '0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        E_waddr = '0; M_waddr = '0; E_tnew = '0; M_tnew = '0;
        D_is_md = 1'b0; E_md_start = '0;
        repeat (2) @(posedge clk);

        // Reset state
        s = idle_stim(); s.rst = 1'b1;
        step(s); #1;
        check("rst_busy", 32'(md_busy), 0);
        check("rst_cnt",  32'(stall_cnt), 0);
        check("rst_pc_en", 32'(pc_en), 1);

        // Load-use hazard from E
        s = idle_stim(); s.rs = 5'd5; s.trs = 2'd0; s.ew = 5'd5; s.et = 2'd2;
        step(s); #1;
        c0 = stall_cnt;
        check("lu_pc_en", 32'(pc_en), 0);
        check("lu_d_en",  32'(d_en), 0);
        check("lu_e_clr", 32'(e_clr), 1);
        step(s); step(s); step(s); #1;
        check("lu_cnt_inc", 32'(stall_cnt), 32'(c0) + 3);

        // M result ready in time: no stall
        s = idle_stim(); s.rs = 5'd5; s.trs = 2'd1; s.mw = 5'd5; s.mt = 2'd1;
        step(s); #1;
        check("nostall_m", 32'(e_clr), 0);
        // Register 0 never stalls
        s = idle_stim(); s.rs = 5'd0; s.trs = 2'd0; s.ew = 5'd0; s.et = 2'd2;
        step(s); #1;
        check("reg0", 32'(pc_en), 1);
        // rt hazard via M
        s = idle_stim(); s.rt = 5'd7; s.trt = 2'd0; s.mw = 5'd7; s.mt = 2'd1;
        step(s); #1;
        check("rt_m", 32'(e_clr), 1);
        // Both E and M match; only E is late
        s = idle_stim(); s.rs = 5'd9; s.trs = 2'd1; s.ew = 5'd9; s.et = 2'd2;
        s.mw = 5'd9; s.mt = 2'd0;
        step(s); #1;
        check("em_both", 32'(e_clr), 1);
        // tuse 3 means unused
        s = idle_stim(); s.rs = 5'd9; s.trs = 2'd3; s.ew = 5'd9; s.et = 2'd2;
        step(s); #1;
        check("tuse3", 32'(e_clr), 0);

        // Mult: start cycle stalls an md instruction, busy for exactly 5
        s = idle_stim(); s.md = 1'b1; s.st = 2'b01;
        step(s); #1;
        check("mult_start_stall", 32'(e_clr), 1);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            s = idle_stim(); s.md = (i == 1);
            step(s); #1;
            if (i == 1) check("mult_busy_stall", 32'(e_clr), 1);
            if (md_busy) nb++;
        end
        check("mult_len", nb, MULT_CYC);

        // Div with an ignored mult start three cycles later: 10 busy total
        s = idle_stim(); s.st = 2'b10;
        step(s);
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            s = idle_stim(); s.st = (i == 2) ? 2'b01 : 2'b00;
            step(s); #1;
            if (md_busy) nb++;
        end
        check("div_len", nb, DIV_CYC);

        // Encoding 11 is no start
        s = idle_stim(); s.st = 2'b11; s.md = 1'b1;
        step(s); #1;
        check("st11_nostall", 32'(e_clr), 0);
        s = idle_stim();
        step(s); #1;
        check("st11_idle", 32'(md_busy), 0);

        // Reset in the 4th busy cycle of a div
        s = idle_stim(); s.st = 2'b10; step(s);
        s = idle_stim(); step(s); step(s); step(s);
        s = idle_stim(); s.rst = 1'b1; s.rs = 5'd3; s.trs = 2'd0; s.ew = 5'd3; s.et = 2'd1;
        step(s); #1;
        check("rst_mid_busy_before", 32'(md_busy), 1);
        check("rst_mid_stall", 32'(e_clr), 1);
        s = idle_stim(); step(s); #1;
        check("rst_mid_busy_after", 32'(md_busy), 0);
        check("rst_mid_cnt_after", 32'(stall_cnt), 0);

        // Random patterns
        for (int i = 0; i < 300; i++) begin
            s.rst = ($urandom_range(0, 49) == 0);
            s.rs  = 5'($urandom_range(0, 3)); s.trs = 2'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3)); s.trt = 2'($urandom_range(0, 3));
            s.ew  = 5'($urandom_range(0, 3)); s.et  = 2'($urandom_range(0, 3));
            s.mw  = 5'($urandom_range(0, 3)); s.mt  = 2'($urandom_range(0, 3));
            s.md  = 1'($urandom_range(0, 1));
            s.st  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(s);
        end

        // Saturation: continuous stall well past 65535 cycles
        s = idle_stim(); s.rst = 1'b1; step(s);
        s = idle_stim(); s.rs = 5'd5; s.trs = 2'd0; s.ew = 5'd5; s.et = 2'd2;
        for (int i = 0; i < 65540; i++) step(s);
        #1;
        check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        step(s); #1;
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);

        s = idle_stim(); step(s);
        @(negedge clk); @(negedge clk);
        if (sb.size() != 0) check("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
